// File: rtl/iod_train_pkg.sv
// -----------------------------------------------------------------------------
// iod_train_pkg
// Shared types and default constants for the DQS/DQ IOD eye trainer.
//   state_t : trainer FSM encoding (IDLE is all-zero so reset reads as IDLE)
//   phase_t : eye sampler window phase
//   DEF_*   : default parameter values for the trainer and sampler
// -----------------------------------------------------------------------------
package iod_train_pkg;

    localparam int DEF_LANES      = 2;
    localparam int DEF_DLY_TAPS   = 128;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_SAMPLE_CYC = 16;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_CLEAR  = 4'd2,
        S_SETTLE = 4'd3,
        S_SAMPLE = 4'd4,
        S_STEP   = 4'd5,
        S_RELOAD = 4'd6,
        S_CENTER = 4'd7,
        S_NEXT   = 4'd8,
        S_FIN    = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETTLE = 2'd1,
        PH_SAMPLE = 2'd2
    } phase_t;

endpackage

// File: rtl/iod_eye_sampler.sv
// -----------------------------------------------------------------------------
// iod_eye_sampler
// Times the settle and observation windows for one tap and OR-accumulates the
// eye-monitor flags of the lane under test.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a new window (settle first, then sample)
//   early    : early flag of the active lane
//   late     : late flag of the active lane
//   phase    : current window phase (debug and sequencing for the trainer)
//   done     : one-cycle pulse after the last sample cycle
//   pass     : held result of the last window, 1 = no flag seen
// -----------------------------------------------------------------------------
module iod_eye_sampler
    import iod_train_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   early,
    input  logic   late,
    output phase_t phase,
    output logic   done,
    output logic   pass
);

    localparam int MAXC = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    logic [CW-1:0] cnt;
    logic          acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            acc   <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                phase <= PH_SETTLE;
                cnt   <= '0;
            end else begin
                case (phase)
                    PH_SETTLE: begin
                        if (cnt == CW'(SETTLE_CYC - 1)) begin
                            phase <= PH_SAMPLE;
                            cnt   <= '0;
                            acc   <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PH_SAMPLE: begin
                        acc <= acc | early | late;
                        if (cnt == CW'(SAMPLE_CYC - 1)) begin
                            phase <= PH_IDLE;
                            done  <= 1'b1;
                            // Include the flags of the final sample cycle.
                            pass  <= ~(acc | early | late);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: phase <= PH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/iod_dqs_eye_trainer.sv
// -----------------------------------------------------------------------------
// iod_dqs_eye_trainer
// Sweeps the IOD delay line of each lane from its static setting upward, finds
// the passing window of the eye monitor, and parks the delay at the window
// centre. Lanes are trained one at a time, lane 0 first.
//   FAB_CLK, ARST            : clock, asynchronous active-high reset
//   START                    : one-cycle training request (honoured in IDLE)
//   EYE_MONITOR_EARLY/LATE   : per-lane eye flags
//   DELAY_LINE_OUT_OF_RANGE  : per-lane delay-line limit
//   DELAY_LINE_LOAD/MOVE     : per-lane one-cycle pulses to the delay line
//   DELAY_LINE_DIRECTION     : per-lane, 1 = increment, active lane only
//   EYE_MONITOR_CLEAR_FLAGS  : per-lane one-cycle flag clear
//   BUSY, DONE               : training in progress / one-cycle completion
//   FAIL                     : sticky per-lane "no passing tap"
//   CENTER_TAP               : per-lane result, lane i at [i*TW +: TW]
//   DBG_STATE                : current FSM state
// Handshake: START is a single-cycle request, accepted only while BUSY is low;
// BUSY rises the cycle after acceptance and falls in the same cycle DONE
// pulses. Results are stable from DONE until the next accepted START.
// -----------------------------------------------------------------------------
module iod_dqs_eye_trainer
    import iod_train_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int DLY_TAPS   = DEF_DLY_TAPS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    localparam int TW        = $clog2(DLY_TAPS)
) (
    input  logic                FAB_CLK,
    input  logic                ARST,
    input  logic                START,
    input  logic [LANES-1:0]    EYE_MONITOR_EARLY,
    input  logic [LANES-1:0]    EYE_MONITOR_LATE,
    input  logic [LANES-1:0]    DELAY_LINE_OUT_OF_RANGE,
    output logic [LANES-1:0]    DELAY_LINE_LOAD,
    output logic [LANES-1:0]    DELAY_LINE_MOVE,
    output logic [LANES-1:0]    DELAY_LINE_DIRECTION,
    output logic [LANES-1:0]    EYE_MONITOR_CLEAR_FLAGS,
    output logic                BUSY,
    output logic                DONE,
    output logic [LANES-1:0]    FAIL,
    output logic [LANES*TW-1:0] CENTER_TAP,
    output state_t              DBG_STATE
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t         state;
    logic [LW-1:0]  lane;
    logic [TW-1:0]  tap;
    logic [TW-1:0]  first_tap;
    logic [TW-1:0]  last_tap;
    logic [TW-1:0]  move_cnt;
    logic           seen;

    logic [LANES-1:0] lane_mask;
    phase_t           smp_phase;
    logic             smp_done;
    logic             smp_pass;

    logic [TW-1:0]  first_n;
    logic [TW-1:0]  last_n;
    logic           seen_n;
    logic           end_sweep;
    logic [TW:0]    center_sum;
    logic [TW-1:0]  center;

    assign DBG_STATE = state;
    assign lane_mask = LANES'(1) << lane;

    iod_eye_sampler #(
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLE_CYC (SAMPLE_CYC)
    ) u_sampler (
        .clk   (FAB_CLK),
        .rst   (ARST),
        .start (state == S_CLEAR),
        .early (EYE_MONITOR_EARLY[lane]),
        .late  (EYE_MONITOR_LATE[lane]),
        .phase (smp_phase),
        .done  (smp_done),
        .pass  (smp_pass)
    );

    // Window bookkeeping for the tap just sampled; used only in STEP.
    assign first_n   = (seen || !smp_pass) ? first_tap : tap;
    assign last_n    = smp_pass ? tap : last_tap;
    assign seen_n    = seen | smp_pass;
    // The sweep stops at the first failing tap after the window, so only one
    // contiguous passing region is ever recorded.
    assign end_sweep = (tap == TW'(DLY_TAPS - 1)) ||
                       DELAY_LINE_OUT_OF_RANGE[lane] ||
                       (seen && !smp_pass);

    // Sum kept one bit wider so FIRST+LAST cannot wrap before halving.
    assign center_sum = {1'b0, first_tap} + {1'b0, last_tap};
    assign center     = TW'(center_sum >> 1);

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state                   <= S_IDLE;
            lane                    <= '0;
            tap                     <= '0;
            first_tap               <= '0;
            last_tap                <= '0;
            move_cnt                <= '0;
            seen                    <= 1'b0;
            DELAY_LINE_LOAD         <= '0;
            DELAY_LINE_MOVE         <= '0;
            DELAY_LINE_DIRECTION    <= '0;
            EYE_MONITOR_CLEAR_FLAGS <= '0;
            BUSY                    <= 1'b0;
            DONE                    <= 1'b0;
            FAIL                    <= '0;
            CENTER_TAP              <= '0;
        end else begin
            DELAY_LINE_LOAD         <= '0;
            DELAY_LINE_MOVE         <= '0;
            EYE_MONITOR_CLEAR_FLAGS <= '0;
            DONE                    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        FAIL                 <= '0;
                        CENTER_TAP           <= '0;
                        BUSY                 <= 1'b1;
                        lane                 <= '0;
                        DELAY_LINE_DIRECTION <= LANES'(1);
                        state                <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    DELAY_LINE_LOAD <= lane_mask;
                    tap             <= '0;
                    first_tap       <= '0;
                    last_tap        <= '0;
                    seen            <= 1'b0;
                    state           <= S_CLEAR;
                end
                S_CLEAR: begin
                    EYE_MONITOR_CLEAR_FLAGS <= lane_mask;
                    state                   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (smp_phase == PH_SAMPLE) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (smp_done) state <= S_STEP;
                end
                S_STEP: begin
                    first_tap <= first_n;
                    last_tap  <= last_n;
                    seen      <= seen_n;
                    if (end_sweep) begin
                        if (seen_n) begin
                            state <= S_RELOAD;
                        end else begin
                            FAIL[lane]                 <= 1'b1;
                            CENTER_TAP[lane*TW +: TW]  <= '0;
                            DELAY_LINE_LOAD            <= lane_mask;
                            state                      <= S_NEXT;
                        end
                    end else begin
                        DELAY_LINE_MOVE <= lane_mask;
                        tap             <= tap + 1'b1;
                        state           <= S_CLEAR;
                    end
                end
                S_RELOAD: begin
                    DELAY_LINE_LOAD <= lane_mask;
                    move_cnt        <= center;
                    state           <= S_CENTER;
                end
                S_CENTER: begin
                    if (move_cnt == '0) begin
                        CENTER_TAP[lane*TW +: TW] <= center;
                        state                     <= S_NEXT;
                    end else begin
                        DELAY_LINE_MOVE <= lane_mask;
                        move_cnt        <= move_cnt - 1'b1;
                    end
                end
                S_NEXT: begin
                    if (lane == LW'(LANES - 1)) begin
                        state <= S_FIN;
                    end else begin
                        lane                 <= lane + 1'b1;
                        DELAY_LINE_DIRECTION <= lane_mask << 1;
                        state                <= S_LOAD;
                    end
                end
                S_FIN: begin
                    DONE                 <= 1'b1;
                    BUSY                 <= 1'b0;
                    DELAY_LINE_DIRECTION <= '0;
                    state                <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iod_dqs_eye_trainer.sv
// -----------------------------------------------------------------------------
// tb_iod_dqs_eye_trainer
// Two-lane bench. A delay-line/eye model follows LOAD/MOVE pulses and drives
// flags from a per-lane passing window. Each training request pushes its
// hand-computed result; the monitor pops and compares on every DONE.
// -----------------------------------------------------------------------------
module tb_iod_dqs_eye_trainer;
  import iod_train_pkg::*;

  localparam int LANES  = 2;
  localparam int TW     = 7;
  localparam int NO_OOR = 1000;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic [2*TW-1:0] center;
    logic [1:0]      fail;
    logic [7:0]      sw0;
    logic [7:0]      cm0;
    logic [7:0]      sw1;
    logic [7:0]      cm1;
  } exp_t;

  // clock / reset
  logic FAB_CLK = 1'b0;
  logic ARST;
  logic START;
  always #5 FAB_CLK = ~FAB_CLK;

  logic [LANES-1:0]    early, late, oor;
  logic [LANES-1:0]    load, move, dir, clr, fail;
  logic                busy, done;
  logic [LANES*TW-1:0] center_tap;
  state_t              dbg_state;

  iod_dqs_eye_trainer #(
    .LANES(LANES), .DLY_TAPS(128), .SETTLE_CYC(8), .SAMPLE_CYC(16)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST                    (ARST),
    .START                   (START),
    .EYE_MONITOR_EARLY       (early),
    .EYE_MONITOR_LATE        (late),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .DELAY_LINE_LOAD         (load),
    .DELAY_LINE_MOVE         (move),
    .DELAY_LINE_DIRECTION    (dir),
    .EYE_MONITOR_CLEAR_FLAGS (clr),
    .BUSY                    (busy),
    .DONE                    (done),
    .FAIL                    (fail),
    .CENTER_TAP              (center_tap),
    .DBG_STATE               (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  // per-lane eye configuration
  int lo[LANES]     = '{1000, 1000};
  int hi[LANES]     = '{-1, -1};
  int oor_at[LANES] = '{NO_OOR, NO_OOR};

  // monitor statistics
  int loads[LANES];
  int moves[LANES];
  int msl[LANES];
  int last0, first1, viol, done_cnt, cyc;
  logic clr1_seen;
  logic busy_q;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk_exp(input int c0, input int c1, input int f,
                                  input int sw0, input int cm0,
                                  input int sw1, input int cm1);
    exp_t e;
    e.center = {TW'(c1), TW'(c0)};
    e.fail   = 2'(f);
    e.sw0    = 8'(sw0);
    e.cm0    = 8'(cm0);
    e.sw1    = 8'(sw1);
    e.cm1    = 8'(cm1);
    return e;
  endfunction

  // delay-line and eye-monitor model
  initial begin
    int mtap[LANES];
    for (int i = 0; i < LANES; i++) mtap[i] = 0;
    early = '1; late = '0; oor = '0;
    forever begin
      @(negedge FAB_CLK);
      for (int i = 0; i < LANES; i++) begin
        if (ARST || load[i]) mtap[i] = 0;
        else if (move[i] && dir[i]) mtap[i] = mtap[i] + 1;
        early[i] = (mtap[i] < lo[i]);
        late[i]  = (mtap[i] > hi[i]);
        oor[i]   = (mtap[i] >= oor_at[i]);
      end
    end
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    busy_q = 1'b0; done_cnt = 0; cyc = 0;
    forever begin
      @(negedge FAB_CLK);
      cyc++;
      if (ARST || (busy && !busy_q)) begin
        for (int i = 0; i < LANES; i++) begin
          loads[i] = 0; moves[i] = 0; msl[i] = 0;
        end
        last0 = -1; first1 = -1; viol = 0; clr1_seen = 1'b0;
      end
      if (!ARST) begin
        for (int i = 0; i < LANES; i++) begin
          if (load[i]) begin loads[i]++; msl[i] = 0; end
          if (move[i]) begin moves[i]++; msl[i]++; end
        end
        if (load[0] || move[0] || clr[0]) last0 = cyc;
        if ((load[1] || move[1] || clr[1]) && first1 < 0) first1 = cyc;
        if (clr[1]) clr1_seen = 1'b1;
        if ($countones(load | move | clr | dir) > 1) viol++;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("center_tap", int'(center_tap), int'(e.center));
            check("fail", int'(fail), int'(e.fail));
            check("sweep_moves0", moves[0] - msl[0], int'(e.sw0));
            check("center_moves0", msl[0], int'(e.cm0));
            check("sweep_moves1", moves[1] - msl[1], int'(e.sw1));
            check("center_moves1", msl[1], int'(e.cm1));
            check("loads0", loads[0], 2);
            check("loads1", loads[1], 2);
            check("lane_order", int'(last0 < first1), 1);
            check("lane_onehot", viol, 0);
            check("busy_at_done", int'(busy), 0);
          end
        end
      end
      busy_q = busy;
    end
  end

  // driver tasks
  task automatic set_eye(input int l0lo, input int l0hi, input int l0oor,
                         input int l1lo, input int l1hi, input int l1oor);
    lo[0] = l0lo; hi[0] = l0hi; oor_at[0] = l0oor;
    lo[1] = l1lo; hi[1] = l1hi; oor_at[1] = l1oor;
  endtask

  task automatic pulse_start();
    @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string name);
    int k = 0;
    while (done_cnt == n0 && k < BUDGET) begin
      @(negedge FAB_CLK);
      k++;
    end
    check({name, "_done_seen"}, int'(done_cnt != n0), 1);
  endtask

  task automatic run_train(input string name, input exp_t e);
    int n0 = done_cnt;
    exp_q.push_back(e);
    pulse_start();
    wait_done(n0, name);
    repeat (5) @(negedge FAB_CLK);
  endtask

  initial begin
    int n0;
    int k;
    ARST = 1'b1;
    START = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    check("rst_lane_outs", int'(load | move | clr | dir | fail), 0);
    check("rst_busy_done", int'({busy, done}), 0);
    check("rst_center", int'(center_tap), 0);
    check("rst_state", int'(dbg_state), int'(S_IDLE));
    ARST = 1'b0;
    repeat (3) @(negedge FAB_CLK);

    // window 20..40 and 10..20
    set_eye(20, 40, NO_OOR, 10, 20, NO_OOR);
    run_train("eye_20_40", mk_exp(30, 15, 0, 41, 30, 21, 15));

    // lane0 never passes; lane1 passes from 45 with range limit at 50
    set_eye(1000, -1, NO_OOR, 45, 127, 50);
    run_train("fail_and_oor", mk_exp(0, 47, 1, 127, 0, 50, 47));

    // windows 10..20 and 60..63
    set_eye(10, 20, NO_OOR, 60, 63, NO_OOR);
    run_train("two_lanes", mk_exp(15, 61, 0, 21, 15, 64, 61));

    // single tap at 0; window 126..127 ending at the last tap
    set_eye(0, 0, NO_OOR, 126, 127, NO_OOR);
    run_train("edges", mk_exp(0, 126, 0, 1, 0, 127, 126));

    // START re-pulsed while busy
    set_eye(20, 40, NO_OOR, 10, 20, NO_OOR);
    n0 = done_cnt;
    exp_q.push_back(mk_exp(30, 15, 0, 41, 30, 21, 15));
    pulse_start();
    repeat (300) @(negedge FAB_CLK);
    check("busy_before_restart", int'(busy), 1);
    pulse_start();
    repeat (600) @(negedge FAB_CLK);
    pulse_start();
    wait_done(n0, "restart");
    repeat (100) @(negedge FAB_CLK);
    check("single_done", done_cnt - n0, 1);

    // asynchronous reset during lane1 sampling
    set_eye(1000, -1, NO_OOR, 45, 127, 50);
    pulse_start();
    k = 0;
    while (!(clr1_seen && dbg_state == S_SAMPLE) && k < BUDGET) begin
      @(negedge FAB_CLK);
      k++;
    end
    check("reached_lane1_sample", int'(clr1_seen && dbg_state == S_SAMPLE), 1);
    check("fail0_before_abort", int'(fail[0]), 1);
    #2 ARST = 1'b1;
    #1;
    check("abort_lane_outs", int'(load | move | clr | dir | fail), 0);
    check("abort_busy_done", int'({busy, done}), 0);
    check("abort_center", int'(center_tap), 0);
    check("abort_state", int'(dbg_state), int'(S_IDLE));
    repeat (3) @(negedge FAB_CLK);
    ARST = 1'b0;
    repeat (10) @(negedge FAB_CLK);
    check("no_load_after_abort", loads[0] + loads[1], 0);
    check("idle_after_abort", int'(dbg_state), int'(S_IDLE));

    // retrain after abort starts again from lane 0
    set_eye(10, 20, NO_OOR, 60, 63, NO_OOR);
    run_train("after_abort", mk_exp(15, 61, 0, 21, 15, 64, 61));

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iod_dqs_eye_trainer.md
IOD_DQS_EYE_TRAINER -- requirements
Module: iod_dqs_eye_trainer

Interface
REQ-001 SHALL have parameter LANES, default 2, number of DQS/DQ IOD lanes trained (1..8).
REQ-002 SHALL have parameter DLY_TAPS, default 128, number of delay-line taps (power of 2, 16..256); TW = clog2(DLY_TAPS).
REQ-003 SHALL have parameter SETTLE_CYC, default 8, idle cycles after each delay change before sampling.
REQ-004 SHALL have parameter SAMPLE_CYC, default 16, eye-monitor observation window per tap in cycles.
REQ-005 SHALL have port FAB_CLK  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port ARST  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port START  in  1  one-cycle request to train all lanes.
REQ-008 SHALL have port EYE_MONITOR_EARLY  in  LANES  per-lane early flag from the IOD.
REQ-009 SHALL have port EYE_MONITOR_LATE  in  LANES  per-lane late flag from the IOD.
REQ-010 SHALL have port DELAY_LINE_OUT_OF_RANGE  in  LANES  per-lane delay-line limit flag.
REQ-011 SHALL have port DELAY_LINE_LOAD  out  LANES  one-cycle pulse, restores the lane's static delay.
REQ-012 SHALL have port DELAY_LINE_MOVE  out  LANES  one-cycle pulse, one tap step.
REQ-013 SHALL have port DELAY_LINE_DIRECTION  out  LANES  1 = increment; held 1 throughout training.
REQ-014 SHALL have port EYE_MONITOR_CLEAR_FLAGS  out  LANES  one-cycle pulse, clears sticky flags.
REQ-015 SHALL have port BUSY  out  1  high while training.
REQ-016 SHALL have port DONE  out  1  one-cycle pulse at training end.
REQ-017 SHALL have port FAIL  out  LANES  sticky per-lane "no passing tap found".
REQ-018 SHALL have port CENTER_TAP  out  LANES*TW  per-lane final tap, lane i at [i*TW +: TW].

Function
REQ-019 SHALL implement FSM IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, RELOAD, CENTER, NEXT, FIN.
REQ-020 SHALL accept START only in IDLE; START in any other state is ignored.
REQ-021 SHALL, on accepted START, clear FAIL and CENTER_TAP, set BUSY next cycle, select lane 0, enter LOAD.
REQ-022 SHALL drive all per-lane outputs only on the bit of the active lane; other bits 0.
REQ-023 LOAD: one DELAY_LINE_LOAD pulse, tap counter := 0, then CLEAR.
REQ-024 CLEAR: one EYE_MONITOR_CLEAR_FLAGS pulse, then SETTLE for exactly SETTLE_CYC cycles, then SAMPLE.
REQ-025 SAMPLE: OR-accumulate EARLY|LATE over exactly SAMPLE_CYC cycles; tap passes iff accumulator is 0.
REQ-026 SHALL record first passing tap (FIRST) and last passing tap (LAST) per sweep.
REQ-027 STEP: end sweep if tap = DLY_TAPS-1, OUT_OF_RANGE is high, or a failing tap follows a passing tap; otherwise one MOVE pulse, tap+1, back to CLEAR.
REQ-028 SHALL compute center = (FIRST+LAST)>>1 in TW+1 bits, floor, result TW bits.
REQ-029 SHALL, if no tap passed, set FAIL[lane], CENTER_TAP[lane] := 0, issue one LOAD pulse, go to NEXT.
REQ-030 RELOAD/CENTER: one LOAD pulse, then exactly center MOVE pulses on consecutive cycles, then CENTER_TAP[lane] := center, go to NEXT.
REQ-031 NEXT: lane+1 -> LOAD; after lane LANES-1 -> FIN.
REQ-032 FIN: DONE pulse for one cycle, BUSY low same cycle, return to IDLE.
REQ-033 SHALL register all outputs (no combinational path input to output).

Reset
REQ-034 ARST SHALL asynchronously force IDLE, lane := 0, counters := 0, all outputs 0 (DIRECTION 0).
REQ-035 ARST mid-training SHALL abort without issuing a LOAD; FAIL and CENTER_TAP read 0 after reset.

Structure
REQ-036 Package iod_train_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-037 Sub-module iod_eye_sampler SHALL implement settle/sample window counting and flag accumulation (REQ-024/025).

Verification
REQ-038 LANES=1, eye passes taps 20..40 -> FIRST 20, LAST 40, 41 sweep MOVEs, LOAD, 30 MOVEs, CENTER_TAP=30, DONE once.
REQ-039 Flags always set -> sweep reaches tap 127, FAIL[0]=1, CENTER_TAP=0, final LOAD, DONE.
REQ-040 Pass 45.., OUT_OF_RANGE at tap 50 -> LAST=50, CENTER_TAP=47.
REQ-041 LANES=2, eyes 10..20 / 60..63 -> lane0 trained fully before lane1 signals move; CENTER_TAP = {61,15}.
REQ-042 START re-pulsed while BUSY -> ignored, single DONE.
REQ-043 ARST during SAMPLE of lane1 -> all outputs 0 asynchronously, IDLE; new START retrains from lane 0.
